// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM encoding and default width.
package divider_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/trial_subtractor.sv
// Combinational trial subtraction for one restoring step: difference = a - b,
// borrow set when b > a (the trial must be discarded).
module trial_subtractor #(
  parameter int W = 5
) (
  input  logic [W-1:0] minuend,
  input  logic [W-1:0] subtrahend,
  output logic [W-1:0] difference,
  output logic         borrow
);

  logic [W:0] full;

  // One extra bit on the left catches the borrow out of the MSB
  always_comb begin
    full       = {1'b0, minuend} - {1'b0, subtrahend};
    difference = full[W-1:0];
    borrow     = full[W];
  end

endmodule

// File: rtl/divider_restoring_4bit.sv
// Multi-cycle restoring divider. One quotient bit per CALC cycle, results
// registered on DONE entry and held until the next DONE entry.
module divider_restoring_4bit
  import divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_Dividend,
  input  logic [WIDTH-1:0] i_Divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_Quotient,
  output logic [WIDTH-1:0] o_Remainder,
  output logic             o_div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH:0]   rem;      // working remainder R
  logic [WIDTH-1:0] quo;      // working quotient Q (starts as the dividend)
  logic [WIDTH-1:0] dvs;      // latched divisor
  logic [CNT_W-1:0] cnt;      // completed steps

  logic [WIDTH:0]   shifted;  // R after the {R,Q} left shift
  logic [WIDTH:0]   diff;
  logic             borrow;

  // R stays below the divisor, so its top bit never feeds the next shift
  logic unused_rem_msb;
  assign unused_rem_msb = rem[WIDTH];

  assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};

  trial_subtractor #(.W(WIDTH + 1)) u_trial (
    .minuend    (shifted),
    .subtrahend ({1'b0, dvs}),
    .difference (diff),
    .borrow     (borrow)
  );

  // FSM, step datapath and result registers; outputs are all registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      rem           <= '0;
      quo           <= '0;
      dvs           <= '0;
      cnt           <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_Quotient    <= '0;
      o_Remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          if (cnt == CNT_W'(WIDTH)) begin
            // All steps done: publish the result
            state         <= DONE;
            o_busy        <= 1'b0;
            o_done        <= 1'b1;
            o_Quotient    <= quo;
            o_Remainder   <= rem[WIDTH-1:0];
            o_div_by_zero <= 1'b0;
          end else begin
            // Keep the trial on no borrow, otherwise restore the shifted R
            rem <= borrow ? shifted : diff;
            quo <= {quo[WIDTH-2:0], ~borrow};
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // IDLE / DONE: a start here is accepted; DONE never lingers
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
          if (i_start) begin
            dvs <= i_Divisor;
            quo <= i_Dividend;
            rem <= '0;
            cnt <= '0;
            if (i_Divisor == '0) begin
              // Divide by zero short-circuits straight to a result
              state         <= DONE;
              o_done        <= 1'b1;
              o_Quotient    <= '1;
              o_Remainder   <= i_Dividend;
              o_div_by_zero <= 1'b1;
            end else begin
              state  <= CALC;
              o_busy <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/divider_restoring_4bit.md
DIVIDER_RESTORING_4BIT -- requirements
Module: divider_restoring_4bit

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits.
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port: i_clk  input  1  rising-edge clock.
REQ-004 SHALL have port: i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: i_start  input  1  request; sampled on rising edge.
REQ-006 SHALL have port: i_Dividend  input  WIDTH  unsigned dividend.
REQ-007 SHALL have port: i_Divisor  input  WIDTH  unsigned divisor.
REQ-008 SHALL have port: o_busy  output  1  high while a division is in progress.
REQ-009 SHALL have port: o_done  output  1  one-cycle pulse when results are valid.
REQ-010 SHALL have port: o_Quotient  output  WIDTH  registered quotient.
REQ-011 SHALL have port: o_Remainder  output  WIDTH  registered remainder.
REQ-012 SHALL have port: o_div_by_zero  output  1  registered flag for the last result.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-014 SHALL, in IDLE or DONE, accept i_start=1 and latch i_Dividend and i_Divisor into working registers.
REQ-015 SHALL, when accepting with non-zero divisor, enter CALC with working remainder R=0, working quotient Q=dividend and iteration counter=0.
REQ-016 SHALL perform one restoring step per CALC cycle:
  - shift {R,Q} left by one;
  - compute a (WIDTH+1)-bit trial T = R - divisor;
  - if T has no borrow: R=T, Q[0]=1;
  - otherwise: R is kept, Q[0]=0.
REQ-017 SHALL leave CALC for DONE after exactly WIDTH steps; the counter SHALL be ceil(log2(WIDTH+1)) bits wide.
REQ-018 SHALL, on entering DONE, load o_Quotient=Q, o_Remainder=R[WIDTH-1:0] and o_div_by_zero=0.
REQ-019 SHALL assert o_done only in the DONE state, which lasts exactly one cycle; the next state is IDLE, or CALC if a start is accepted in that cycle.
REQ-020 SHALL, for a normal division, assert o_done in the cycle beginning WIDTH+1 rising edges after the edge that sampled i_start.
REQ-021 SHALL, when accepting with divisor=0, go directly to DONE with o_Quotient all ones, o_Remainder=dividend and o_div_by_zero=1, so that o_done asserts on the next cycle.
REQ-022 SHALL drive o_busy=1 exactly while in CALC.
REQ-023 SHALL ignore i_start while in CALC; the operation in progress is unaffected.
REQ-024 SHALL hold o_Quotient, o_Remainder and o_div_by_zero from one DONE entry until the next DONE entry; they stay unchanged during CALC.
REQ-025 SHALL never produce X on any output, for any combination of inputs.

Reset
REQ-026 SHALL, on i_rst_n=0, immediately and without waiting for a clock edge:
  - set the state to IDLE;
  - clear o_busy, o_done, o_Quotient, o_Remainder, o_div_by_zero, the counter and the working registers.
REQ-027 SHALL abandon any division in progress when reset is asserted mid-CALC, with no o_done pulse afterwards.
REQ-028 SHALL accept i_start on the first rising edge after i_rst_n deasserts.

Structure
REQ-029 SHALL take the FSM state encoding (IDLE, CALC, DONE) and the default WIDTH from a shared package, divider_pkg.
REQ-030 SHALL place the (WIDTH+1)-bit trial subtraction in one combinational sub-module, trial_subtractor, with outputs difference and borrow.
REQ-031 SHALL keep the FSM, counter and result registers in divider_restoring_4bit.

Verification
REQ-032 SHALL cover: 13/3 -> o_done 5 cycles after start; Q=4, R=1, div_by_zero=0.
REQ-033 SHALL cover: 15/1 -> Q=15, R=0; then 2/9 started in the DONE cycle -> Q=0, R=2, with o_done 5 cycles later.
REQ-034 SHALL cover: 7/0 -> o_done on the next cycle; Q=15, R=7, div_by_zero=1, o_busy never high.
REQ-035 SHALL cover: 12/5 started, then i_start with 9/2 in CALC cycle 2 -> second request ignored; result Q=2, R=2.
REQ-036 SHALL cover: reset asserted in CALC cycle 3 of 14/4 -> all outputs 0 immediately; no o_done; a new 9/3 after release gives Q=3, R=0.
REQ-037 SHALL cover: an exhaustive sweep of all 256 operand pairs against a reference model: Q*D+R=dividend and R<D for D!=0.
